stripes_bitserial_ctrl: RTL and testbench
=========================================

Name: stripes_bitserial_ctrl

Overview:
- Sequencer for the 16-lane Stripes bit-serial MAC unit.
- Accepts a run of weight vectors over a valid/ready interface and streams each vector bit-serially, MSB first, onto the MAC's per-lane weight-bit inputs.
- Generates the MAC's enable, is_msb and is_msb_delayed controls, plus a per-group result-valid strobe.
- Sits between the weight buffer and the MAC array; one controller may drive many MAC units sharing the same weights.

Parameters:
- VEC_LENGTH, 16, number of lanes (weights per vector).
- W_PREC, 8, maximum weight precision in bits.
- PREC_WIDTH, 4, width of the precision config field; must hold the value W_PREC.
- GRP_WIDTH, 8, width of the group-count config and index.

Ports:
- clk, input, 1: single clock, all logic on posedge.
- reset, input, 1: synchronous, active-low; state is cleared on a clk edge when reset==0.
- start, input, 1: pulse that launches a run; sampled only in IDLE.
- cfg_prec, input, PREC_WIDTH: weight precision P, sampled at start; 0 or >W_PREC is treated as W_PREC.
- cfg_groups, input, GRP_WIDTH: number of weight vectors N in the run, sampled at start.
- w_valid, input, 1: weight vector valid.
- w_ready, output, 1: controller ready to accept a weight vector.
- w_data, input, [W_PREC-1:0] x VEC_LENGTH unpacked: two's-complement weights; only bits [P-1:0] are used.
- mac_en, output, 1: MAC enable.
- mac_w_bit, output, 1 x VEC_LENGTH unpacked: current weight bit per lane.
- mac_is_msb, output, 1: the current bit is the sign bit.
- mac_is_msb_delayed, output, 1: mac_is_msb delayed by one enabled cycle.
- result_valid, output, 1: one-cycle strobe; MAC result for the current group is valid this cycle.
- group_idx, output, GRP_WIDTH: index of the current group.
- busy, output, 1: high whenever state != IDLE.
- done, output, 1: one-cycle strobe when the run completes.

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE. All outputs 0, including the mac_w_bit lanes and group_idx. Latched weights, bit_cnt and group count are cleared. Reset mid-run aborts immediately; no done or result_valid is issued.
- States: IDLE, FETCH, BIT, DRAIN, RESULT.
- IDLE:
  - On start: latch P and N, set group_idx=0.
  - If N==0: stay in IDLE and pulse done on the next cycle.
  - Otherwise go to FETCH.
- FETCH:
  - w_ready=1, mac_en=0 (the MAC holds its state).
  - On w_valid&&w_ready: latch w_data, set bit_cnt=P-1, go to BIT.
  - Indefinite stalls are legal.
- BIT:
  - mac_en=1.
  - mac_w_bit[j] = latched w_data[j][bit_cnt].
  - mac_is_msb = (bit_cnt==P-1).
  - bit_cnt decrements each cycle; when bit_cnt==0, go to DRAIN. BIT therefore lasts exactly P cycles.
- DRAIN:
  - Exactly 1 cycle: mac_en=1, mac_w_bit all 0, mac_is_msb=0.
  - Flushes the MAC's psum register into the accumulator. Mandatory, because the MAC's psum path has one register stage.
- RESULT:
  - Exactly 1 cycle: mac_en=0, result_valid=1, and the MAC output reflects the group at group_idx.
  - If group_idx==N-1: pulse done in this same cycle and return to IDLE.
  - Otherwise increment group_idx and go to FETCH.
- mac_is_msb_delayed:
  - Registered copy of mac_is_msb, updated only in cycles where mac_en=1; cleared in IDLE.
  - It is high exactly in the enabled cycle following the MSB cycle.
  - For P=1 that cycle is DRAIN.
- Outputs in non-BIT states: mac_w_bit is 0 and mac_is_msb is 0.
- w_ready=0 in every state except FETCH.
- start during busy is ignored.
- cfg_* changes after start have no effect on the run in progress.
- Latency per group, with w_valid held high: 1 (FETCH) + P + 1 + 1 = P+3 cycles. First result_valid comes P+4 cycles after the start cycle.

Test Plan:
- P=8, N=1:
  - Stimulus: start; lane0 weight 8'sb1000_0001 (−127), other lanes 0; w_valid held.
  - Response: lane0 mac_w_bit sequence 1,0,0,0,0,0,0,1 over 8 BIT cycles; mac_is_msb only in the first; mac_is_msb_delayed only in the second; mac_en high 9 cycles; result_valid at start+12; done in the same cycle.
- P=1, N=2:
  - Stimulus: weights all-ones, then all-zeros.
  - Response: per group, 1 BIT cycle with mac_is_msb=1 and mac_w_bit all 1s (then all 0s), followed by a DRAIN cycle with mac_is_msb_delayed=1; result_valid twice, 4 cycles apart; group_idx 0 then 1.
- Stall:
  - Stimulus: N=3, P=4; w_valid low for 5 cycles before the second vector.
  - Response: mac_en=0 and w_ready=1 throughout the stall; no output glitch; total run = 3·7+5 cycles.
- Config edges:
  - Stimulus: start with N=0 → required response: done one cycle later, busy never set.
  - Stimulus: cfg_prec=0 → required response: P=8 behaviour.
  - Stimulus: cfg_prec=12 → required response: P=8 behaviour.
- Reset mid-BIT:
  - Stimulus: drive reset=0 on bit_cnt=3.
  - Response: next cycle all outputs 0, state IDLE, no done. A fresh start then runs normally.
- start asserted while busy:
  - Response: ignored; run length and group_idx are unaffected.

Source files
------------

// File: rtl/stripes_bitserial_ctrl.sv
// rtl/stripes_bitserial_ctrl.sv - bit-serial weight sequencer for the 16-lane Stripes MAC
// MAC-facing controls, result_valid and done are registered and trail the FSM state by one cycle.
module stripes_bitserial_ctrl #(
  parameter int VEC_LENGTH = 16,
  parameter int W_PREC     = 8,
  parameter int PREC_WIDTH = 4,
  parameter int GRP_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [PREC_WIDTH-1:0] cfg_prec,
  input  logic [GRP_WIDTH-1:0]  cfg_groups,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [W_PREC-1:0]     w_data [VEC_LENGTH],
  output logic                  mac_en,
  output logic                  mac_w_bit [VEC_LENGTH],
  output logic                  mac_is_msb,
  output logic                  mac_is_msb_delayed,
  output logic                  result_valid,
  output logic [GRP_WIDTH-1:0]  group_idx,
  output logic                  busy,
  output logic                  done
);
  localparam int BIT_W = (W_PREC > 1) ? $clog2(W_PREC) : 1;
  localparam logic [PREC_WIDTH-1:0] PREC_MAX = PREC_WIDTH'(W_PREC);

  typedef enum logic [2:0] {IDLE, FETCH, BIT, DRAIN, RESULT} state_t;
  state_t state, state_nxt;

  logic [PREC_WIDTH-1:0] prec_q, bit_cnt, prec_eff;
  logic [GRP_WIDTH-1:0]  groups_q, grp_cnt;
  logic [W_PREC-1:0]     w_q [VEC_LENGTH];
  logic                  last_grp, last_bit;
  logic                  en_c, msb_c, rv_c, done_c;
  logic                  wbit_c [VEC_LENGTH];

  assign prec_eff = (cfg_prec == '0 || cfg_prec > PREC_MAX) ? PREC_MAX : cfg_prec;
  assign last_grp = (grp_cnt == groups_q - GRP_WIDTH'(1));
  assign last_bit = (bit_cnt == '0);
  assign w_ready  = (state == FETCH);
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    en_c      = 1'b0;
    msb_c     = 1'b0;
    rv_c      = 1'b0;
    done_c    = 1'b0;
    for (int j = 0; j < VEC_LENGTH; j++) wbit_c[j] = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (cfg_groups == '0) done_c = 1'b1;
          else                  state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (w_valid) state_nxt = BIT;
      end
      BIT: begin
        en_c  = 1'b1;
        msb_c = (bit_cnt == prec_q - PREC_WIDTH'(1));
        for (int j = 0; j < VEC_LENGTH; j++) wbit_c[j] = w_q[j][bit_cnt[BIT_W-1:0]];
        if (last_bit) state_nxt = DRAIN;
      end
      DRAIN: begin
        // one extra enabled cycle flushes the MAC's registered psum into its accumulator
        en_c      = 1'b1;
        state_nxt = RESULT;
      end
      RESULT: begin
        rv_c = 1'b1;
        if (last_grp) begin
          done_c    = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state              <= IDLE;
      prec_q             <= '0;
      groups_q           <= '0;
      grp_cnt            <= '0;
      bit_cnt            <= '0;
      mac_en             <= 1'b0;
      mac_is_msb         <= 1'b0;
      mac_is_msb_delayed <= 1'b0;
      result_valid       <= 1'b0;
      group_idx          <= '0;
      done               <= 1'b0;
      for (int j = 0; j < VEC_LENGTH; j++) begin
        w_q[j]       <= '0;
        mac_w_bit[j] <= 1'b0;
      end
    end else begin
      state        <= state_nxt;
      mac_en       <= en_c;
      mac_is_msb   <= msb_c;
      result_valid <= rv_c;
      done         <= done_c;
      for (int j = 0; j < VEC_LENGTH; j++) mac_w_bit[j] <= wbit_c[j];
      group_idx <= (state == IDLE && start) ? '0 : grp_cnt;
      if (state == IDLE)  mac_is_msb_delayed <= 1'b0;
      else if (mac_en)    mac_is_msb_delayed <= mac_is_msb;
      case (state)
        IDLE: begin
          if (start) begin
            prec_q   <= prec_eff;
            groups_q <= cfg_groups;
            grp_cnt  <= '0;
          end
        end
        FETCH: begin
          if (w_valid) begin
            for (int j = 0; j < VEC_LENGTH; j++) w_q[j] <= w_data[j];
            bit_cnt <= prec_q - PREC_WIDTH'(1);
          end
        end
        BIT: begin
          if (!last_bit) bit_cnt <= bit_cnt - PREC_WIDTH'(1);
        end
        RESULT: begin
          if (!last_grp) grp_cnt <= grp_cnt + GRP_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_stripes_bitserial_ctrl.sv
// tb/tb_stripes_bitserial_ctrl.sv - randomized run-level model check of stripes_bitserial_ctrl
module tb_stripes_bitserial_ctrl;
  localparam int VL = 16, WP = 8, PW = 4, GW = 8, MAXC = 256;

  logic          clk = 1'b0;
  logic          reset, start, w_valid, w_ready;
  logic [PW-1:0] cfg_prec;
  logic [GW-1:0] cfg_groups;
  logic [WP-1:0] w_data [VL];
  logic          mac_en, mac_is_msb, mac_is_msb_delayed, result_valid, busy, done;
  logic          mac_w_bit [VL];
  logic [GW-1:0] group_idx;

  always #5 clk = ~clk;

  stripes_bitserial_ctrl #(.VEC_LENGTH(VL), .W_PREC(WP), .PREC_WIDTH(PW), .GRP_WIDTH(GW)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_prec(cfg_prec), .cfg_groups(cfg_groups),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .mac_en(mac_en),
    .mac_w_bit(mac_w_bit), .mac_is_msb(mac_is_msb), .mac_is_msb_delayed(mac_is_msb_delayed),
    .result_valid(result_valid), .group_idx(group_idx), .busy(busy), .done(done)
  );

  int checks = 0, errors = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  // expected per-cycle trace of the current run, built from the run schedule
  logic [VL-1:0] e_wbit [MAXC];
  bit e_en [MAXC], e_msb [MAXC], e_msbd [MAXC], e_rv [MAXC], e_done [MAXC], e_busy [MAXC], e_wr [MAXC];
  int e_gidx [MAXC];
  int gidx_prev = 0;

  logic [WP-1:0] wts [8][VL];
  int stall [8];

  int mon_en, mon_busy;
  logic [8:0] mon_lane0;
  int rv_q[$];
  int gidx_at_rv[$];
  logic [VL-1:0] wb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int j = 0; j < VL; j++) wb[j] = mac_w_bit[j];
      chk("mac_en", mac_en, e_en[cyc]);
      chk("mac_w_bit", wb, e_wbit[cyc]);
      chk("mac_is_msb", mac_is_msb, e_msb[cyc]);
      chk("mac_is_msb_delayed", mac_is_msb_delayed, e_msbd[cyc]);
      chk("result_valid", result_valid, e_rv[cyc]);
      chk("done", done, e_done[cyc]);
      chk("busy", busy, e_busy[cyc]);
      chk("w_ready", w_ready, e_wr[cyc]);
      chk("group_idx", group_idx, e_gidx[cyc]);
      if (mac_en) begin
        mon_en++;
        mon_lane0 = {mon_lane0[7:0], mac_w_bit[0]};
      end
      if (busy) mon_busy++;
      if (result_valid) begin
        rv_q.push_back(cyc);
        gidx_at_rv.push_back(int'(group_idx));
      end
    end
  end

  task automatic run(input int pcfg, input int n, input int abort_c, input bit busy_start);
    int p, cur, len, g;
    int f [8];
    int h [8];
    p = (pcfg == 0 || pcfg > WP) ? WP : pcfg;
    for (int c = 0; c < MAXC; c++) begin
      e_wbit[c] = '0; e_en[c] = 0; e_msb[c] = 0; e_msbd[c] = 0; e_rv[c] = 0;
      e_done[c] = 0; e_busy[c] = 0; e_wr[c] = 0; e_gidx[c] = gidx_prev;
    end
    cur = 1;
    for (int gg = 0; gg < n; gg++) begin
      f[gg] = cur;
      h[gg] = cur + stall[gg];
      cur = h[gg] + p + 3;
    end
    if (n == 0) begin
      len = 1;
      e_done[1] = 1;
      for (int c = 1; c < MAXC; c++) e_gidx[c] = 0;
    end else begin
      len = h[n-1] + p + 3;
      for (int c = 1; c < len; c++) e_busy[c] = 1;
      for (int gg = 0; gg < n; gg++) begin
        for (int c = f[gg]; c <= h[gg]; c++) e_wr[c] = 1;
        for (int k = 0; k < p; k++) begin
          e_en[h[gg]+2+k]  = 1;
          e_msb[h[gg]+2+k] = (k == 0);
          for (int j = 0; j < VL; j++) e_wbit[h[gg]+2+k][j] = wts[gg][j][p-1-k];
        end
        e_en[h[gg]+p+2] = 1;
        e_msbd[h[gg]+3] = 1;
        e_rv[h[gg]+p+3] = 1;
        for (int c = (gg == 0) ? 1 : f[gg] + 1; c < MAXC; c++) e_gidx[c] = gg;
      end
      e_done[len] = 1;
    end
    if (abort_c >= 0) begin
      for (int c = abort_c + 1; c < MAXC; c++) begin
        e_wbit[c] = '0; e_en[c] = 0; e_msb[c] = 0; e_msbd[c] = 0; e_rv[c] = 0;
        e_done[c] = 0; e_busy[c] = 0; e_wr[c] = 0; e_gidx[c] = 0;
      end
      len = abort_c + 1;
    end
    mon_en = 0; mon_busy = 0; mon_lane0 = '0;
    rv_q.delete(); gidx_at_rv.delete();
    chk_on = 1'b1;
    for (int c = 0; c <= len + 2; c++) begin
      @(posedge clk); #1;
      cyc = c;
      reset = !(c == abort_c);
      start = (c == 0) || (busy_start && abort_c < 0 && c >= 2 && c <= len - 2 && $urandom_range(0, 3) == 0);
      cfg_prec   = (c == 0) ? PW'(pcfg) : PW'($urandom);
      cfg_groups = (c == 0) ? GW'(n) : GW'($urandom);
      g = n;
      for (int gg = 0; gg < n; gg++) begin
        if (h[gg] >= c) begin g = gg; break; end
      end
      w_valid = 1'b1;
      if (g < n && c >= f[g] && c < f[g] + stall[g]) w_valid = 1'b0;
      for (int j = 0; j < VL; j++) w_data[j] = (g < n) ? wts[g][j] : WP'($urandom);
    end
    @(negedge clk); #1;
    start = 1'b0;
    gidx_prev = e_gidx[len + 2];
  endtask

  task automatic rand_wts();
    for (int g = 0; g < 8; g++) begin
      stall[g] = 0;
      for (int j = 0; j < VL; j++) wts[g][j] = WP'($urandom);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; cfg_prec = '0; cfg_groups = '0; w_valid = 1'b0;
    for (int j = 0; j < VL; j++) w_data[j] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int j = 0; j < VL; j++) wb[j] = mac_w_bit[j];
    chk("rst_mac_en", mac_en, 0);
    chk("rst_w_bits", wb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_group_idx", group_idx, 0);
    chk("rst_done_rv", {done, result_valid, mac_is_msb, mac_is_msb_delayed}, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // P=8, N=1, lane0 = -127
    for (int g = 0; g < 8; g++) begin
      stall[g] = 0;
      for (int j = 0; j < VL; j++) wts[g][j] = '0;
    end
    wts[0][0] = 8'b1000_0001;
    run(8, 1, -1, 0);
    chk("t1_rv_count", rv_q.size(), 1);
    if (rv_q.size() == 1) chk("t1_rv_cycle", rv_q[0], 12);
    chk("t1_en_cycles", mon_en, 9);
    chk("t1_lane0_seq", mon_lane0, 9'b1_0000_0010);

    // P=1, N=2: all ones then all zeros
    for (int j = 0; j < VL; j++) begin wts[0][j] = '1; wts[1][j] = '0; end
    run(1, 2, -1, 0);
    chk("t2_rv_count", rv_q.size(), 2);
    if (rv_q.size() == 2) begin
      chk("t2_rv_spacing", rv_q[1] - rv_q[0], 4);
      chk("t2_gidx0", gidx_at_rv[0], 0);
      chk("t2_gidx1", gidx_at_rv[1], 1);
    end

    // N=3, P=4, five-cycle stall before the second vector, with stray starts
    rand_wts();
    stall[1] = 5;
    run(4, 3, -1, 1);
    chk("t3_busy_cycles", mon_busy, 3 * 7 + 5);
    chk("t3_rv_count", rv_q.size(), 3);

    // N=0
    run(5, 0, -1, 0);
    chk("t4_busy_cycles", mon_busy, 0);

    // precision 0 and 12 both behave as 8
    rand_wts();
    run(0, 1, -1, 0);
    chk("t5_en_cycles", mon_en, 9);
    rand_wts();
    run(12, 1, -1, 0);
    chk("t6_en_cycles", mon_en, 9);

    // reset while bit_cnt==3 on the first group, then a fresh run
    rand_wts();
    run(8, 2, 6, 0);
    chk("t7_rv_count", rv_q.size(), 0);
    rand_wts();
    run(3, 2, -1, 0);
    chk("t8_rv_count", rv_q.size(), 2);

    // randomized runs
    for (int r = 0; r < 12; r++) begin
      int n;
      rand_wts();
      n = $urandom_range(1, 4);
      for (int g = 0; g < n; g++) stall[g] = $urandom_range(0, 3);
      run($urandom_range(0, 15), n, -1, 1);
      chk("rand_rv_count", rv_q.size(), n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
